// File: rtl/alu_stateful_v2_if.sv
// Action/operand request bus and result bus between the sub-action decoder and
// the stateful ALU of one PHV container slot.
interface alu_stateful_v2_if #(
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32
);
    logic [ACTION_LEN-1:0] action_in;
    logic                  action_valid;
    logic [DATA_WIDTH-1:0] operand_1_in;
    logic [DATA_WIDTH-1:0] operand_2_in;
    logic [DATA_WIDTH-1:0] operand_3_in;
    logic                  action_ready;
    logic [DATA_WIDTH-1:0] container_out;
    logic                  container_out_valid;

    modport master (
        output action_in,
        output action_valid,
        output operand_1_in,
        output operand_2_in,
        output operand_3_in,
        input  action_ready,
        input  container_out,
        input  container_out_valid
    );

    modport slave (
        input  action_in,
        input  action_valid,
        input  operand_1_in,
        input  operand_2_in,
        input  operand_3_in,
        output action_ready,
        output container_out,
        output container_out_valid
    );
endinterface

// File: rtl/alu_stateful_v2.sv
// Stateful ALU for one PHV container slot: add/sub, load, store, atomic ldadd, pass-through.
// Latency: result valid 3 cycles after accept (4 for ldadd); one action in flight at a time.
// Backpressure: action_ready high only in IDLE; ALU_RAM_CLEAR_EN adds a post-reset RAM zeroing sweep.
module alu_stateful_v2 #(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_stateful_v2_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    localparam logic [3:0] OP_LDADD = 4'b0111;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        EXEC,
        RD,
        WB,
        OUT
    } state_t;

    state_t                state;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [DATA_WIDTH-1:0] op3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  store_en;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] container_q;
    logic                  valid_q;
    logic                  ready_q;
`ifdef ALU_RAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] init_addr;
`endif

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] ldadd_sum;

    logic [3:0] opc;
    logic       is_mem_rd;
    logic       unused_act_bits;

    assign opc             = bus.action_in[ACTION_LEN-1 -: 4];
    assign is_mem_rd       = (opc == OP_LOAD) || (opc == OP_LDADD);
    assign unused_act_bits = ^bus.action_in[ACTION_LEN-5:0];
    assign ldadd_sum       = ram_q + op1_q;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = addr_q;
        mem_wd = op1_q;
        case (state)
            EXEC: mem_we = store_en;
            WB: begin
                mem_we = 1'b1;
                mem_wd = ldadd_sum;
            end
`ifdef ALU_RAM_CLEAR_EN
            INIT: begin
                mem_we = 1'b1;
                mem_wa = init_addr;
                mem_wd = '0;
            end
`endif
            default: ;
        endcase
    end

    // RAM is not reset; a write that coincides with an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
        ram_q <= mem[addr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef ALU_RAM_CLEAR_EN
            state     <= INIT;
            ready_q   <= 1'b0;
            init_addr <= '0;
`else
            state     <= IDLE;
            ready_q   <= 1'b1;
`endif
            op_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            op3_q       <= '0;
            addr_q      <= '0;
            store_en    <= 1'b0;
            result_q    <= '0;
            container_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
`ifdef ALU_RAM_CLEAR_EN
                INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == '1) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
`endif
                IDLE: begin
                    if (bus.action_valid && ready_q) begin
                        ready_q  <= 1'b0;
                        op_q     <= opc;
                        op1_q    <= bus.operand_1_in;
                        op2_q    <= bus.operand_2_in;
                        op3_q    <= bus.operand_3_in;
                        addr_q   <= bus.operand_2_in[ADDR_WIDTH-1:0];
                        store_en <= (opc == OP_STORE);
                        state    <= is_mem_rd ? RD : EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD, OP_ADDI: result_q <= op1_q + op2_q;
                        OP_SUB, OP_SUBI: result_q <= op1_q - op2_q;
                        default:         result_q <= op3_q;
                    endcase
                    store_en <= 1'b0;
                    state    <= OUT;
                end
                // Read data lands in ram_q on this edge; a plain load picks it up in OUT.
                RD: begin
                    state <= (op_q == OP_LDADD) ? WB : OUT;
                end
                WB: begin
                    result_q <= ldadd_sum;
                    state    <= OUT;
                end
                OUT: begin
                    container_q <= (op_q == OP_LOAD) ? ram_q : result_q;
                    valid_q     <= 1'b1;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.action_ready        = ready_q;
    assign bus.container_out       = container_q;
    assign bus.container_out_valid = valid_q;

endmodule

// File: tb/tb_alu_stateful_v2.sv
// Directed bench for alu_stateful_v2: arithmetic, memory ops, ldadd, backpressure, mid-op reset.
module tb_alu_stateful_v2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_stateful_v2_if bus_if ();

    alu_stateful_v2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int errors = 0;
    int checks = 0;

`ifdef ALU_RAM_CLEAR_EN
    localparam logic [31:0] RST_READY = 32'd0;
`else
    localparam logic [31:0] RST_READY = 32'd1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] opc, input logic [31:0] o1, input logic [31:0] o2,
                         input logic [31:0] o3, input logic vld);
        logic [24:0] act;
        act = '0;
        act[24:21] = opc;
        bus_if.action_in    = act;
        bus_if.operand_1_in = o1;
        bus_if.operand_2_in = o2;
        bus_if.operand_3_in = o3;
        bus_if.action_valid = vld;
    endtask

    // Presents one action at a negedge, scrambles the inputs after acceptance and
    // checks the latency (in negedges after the accept edge) and the result.
    task automatic run_op(input string tag, input logic [3:0] opc, input logic [31:0] o1,
                          input logic [31:0] o2, input logic [31:0] o3, input logic [31:0] exp,
                          input int lat, input bit hold_chk);
        int n;
        bit seen;
        n = 0;
        while (bus_if.action_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, {31'd0, bus_if.action_ready}, 32'd1);
        drive(opc, o1, o2, o3, 1'b1);
        @(negedge clk);
        drive(4'b0001, 32'hA5A5_5A5A, 32'h0000_001F, 32'hCAFE_F00D, 1'b0);
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 8) begin
            if (bus_if.container_out_valid === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_val"}, bus_if.container_out, exp);
        if (hold_chk) begin
            @(negedge clk);
            chk({tag, "_vld_drop"}, {31'd0, bus_if.container_out_valid}, 32'd0);
            chk({tag, "_hold"}, bus_if.container_out, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;
        int readys;
        logic [31:0] exp_hold [3];

        rst = 1'b1;
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_out", bus_if.container_out, 32'd0);
        chk("rst_vld", {31'd0, bus_if.container_out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, bus_if.action_ready}, RST_READY);
        rst = 1'b0;

`ifdef ALU_RAM_CLEAR_EN
        n = 0;
        while (bus_if.action_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("clear_ready_delay", n, 32'd32);
        run_op("clear_ld9", 4'b1011, 32'd0, 32'd9, 32'd0, 32'd0, 3, 1'b1);
        run_op("clear_ld31", 4'b1011, 32'd0, 32'd31, 32'd0, 32'd0, 3, 1'b1);
`else
        @(negedge clk);
`endif

        run_op("add", 4'b0001, 32'd5, 32'd7, 32'd0, 32'd12, 3, 1'b1);
        run_op("addi", 4'b1001, 32'h10, 32'h20, 32'd0, 32'h30, 3, 1'b1);
        run_op("sub", 4'b0010, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 3, 1'b1);
        run_op("subi", 4'b1010, 32'd100, 32'd1, 32'd0, 32'd99, 3, 1'b1);
        run_op("store3", 4'b1000, 32'hDEAD_BEEF, 32'd3, 32'h11, 32'h11, 3, 1'b1);
        run_op("load3", 4'b1011, 32'd0, 32'd3, 32'h55, 32'hDEAD_BEEF, 3, 1'b1);
        run_op("load_trunc", 4'b1011, 32'd0, 32'h23, 32'h55, 32'hDEAD_BEEF, 3, 1'b1);

        run_op("store7", 4'b1000, 32'd0, 32'd7, 32'h22, 32'h22, 3, 1'b1);
        run_op("ldadd7_a", 4'b0111, 32'd1, 32'd7, 32'd0, 32'd1, 4, 1'b0);
        run_op("ldadd7_b", 4'b0111, 32'd1, 32'd7, 32'd0, 32'd2, 4, 1'b0);
        run_op("ldadd7_c", 4'b0111, 32'd1, 32'd7, 32'd0, 32'd3, 4, 1'b1);
        run_op("load7", 4'b1011, 32'd0, 32'd7, 32'd0, 32'd3, 3, 1'b1);

        run_op("store10", 4'b1000, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0, 3, 1'b1);
        run_op("ldadd_wrap", 4'b0111, 32'd2, 32'd10, 32'd0, 32'd1, 4, 1'b1);

        run_op("nop5", 4'b0101, 32'd1, 32'd2, 32'hAB, 32'hAB, 3, 1'b1);
        run_op("nop0", 4'b0000, 32'd1, 32'd2, 32'h1234, 32'h1234, 3, 1'b1);

        // valid held high with a new action every cycle: only ready windows accept
        exp_hold[0] = 32'd100;
        exp_hold[1] = 32'd203;
        exp_hold[2] = 32'd106;
        pulses = 0;
        readys = 0;
        for (int k = 0; k < 9; k++) begin
            if (k % 2 == 0) drive(4'b0001, k, 32'd100, 32'd0, 1'b1);
            else            drive(4'b0101, k, 32'd100, 200 + k, 1'b1);
            @(negedge clk);
            if (bus_if.action_ready === 1'b1) readys++;
            if (bus_if.container_out_valid === 1'b1) begin
                if (pulses < 3) chk("hold_val", bus_if.container_out, exp_hold[pulses]);
                pulses++;
            end
        end
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("hold_pulses", pulses, 32'd3);
        chk("hold_ready_windows", readys, 32'd3);

        // reset lands before the ldadd write edge
        run_op("store4", 4'b1000, 32'd9, 32'd4, 32'h77, 32'h77, 3, 1'b1);
        drive(4'b0111, 32'd5, 32'd4, 32'd0, 1'b1);
        @(negedge clk);
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out", bus_if.container_out, 32'd0);
        chk("midrst_vld", {31'd0, bus_if.container_out_valid}, 32'd0);
        chk("midrst_rdy", {31'd0, bus_if.action_ready}, RST_READY);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_if.container_out_valid === 1'b1) pulses++;
        end
        chk("midrst_no_valid", pulses, 32'd0);
`ifdef ALU_RAM_CLEAR_EN
        run_op("midrst_load4", 4'b1011, 32'd0, 32'd4, 32'd0, 32'd0, 3, 1'b1);
`else
        run_op("midrst_load4", 4'b1011, 32'd0, 32'd4, 32'd0, 32'd9, 3, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
